// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : memory_arbiter
// Description : Three-requester single-port memory arbiter (fetch/read/write)
//               with fixed priority and fetch anti-starvation.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_arbiter #(
    parameter int WIDTH        = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             fetch_enable,
    input  logic [WIDTH-1:0] fetch_address,
    input  logic             read_enable,
    input  logic [WIDTH-1:0] read_address,
    input  logic             write_enable,
    input  logic [WIDTH-1:0] write_address,
    input  logic [WIDTH-1:0] write_data,
    output logic             fetch_valid,
    output logic             read_valid,
    output logic             write_done,
    output logic [WIDTH-1:0] response_data,
    output logic             mem_request,
    output logic             mem_write,
    output logic [WIDTH-1:0] mem_address,
    output logic [WIDTH-1:0] mem_write_data,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_read_data
);

    localparam int                 c_CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_BUSY    = 2'd1;
    localparam logic [1:0] c_RESPOND = 2'd2;

    localparam logic [1:0] c_G_FETCH = 2'd0;
    localparam logic [1:0] c_G_READ  = 2'd1;
    localparam logic [1:0] c_G_WRITE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         r_grant;
    logic [c_CNT_W-1:0] r_starve;
    logic [WIDTH-1:0]   r_addr;
    logic [WIDTH-1:0]   r_wdata;
    logic [WIDTH-1:0]   r_rdata;

    logic               w_any;
    logic               w_starved;
    logic [1:0]         w_grant;
    logic [WIDTH-1:0]   w_addr;

    assign w_any     = fetch_enable | read_enable | write_enable;
    assign w_starved = fetch_enable && (r_starve == c_LIMIT);

    always_comb begin
        w_grant = c_G_FETCH;
        w_addr  = fetch_address;
        if (w_starved) begin
            w_grant = c_G_FETCH;
            w_addr  = fetch_address;
        end else if (write_enable) begin
            w_grant = c_G_WRITE;
            w_addr  = write_address;
        end else if (read_enable) begin
            w_grant = c_G_READ;
            w_addr  = read_address;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= c_IDLE;
            r_grant  <= c_G_FETCH;
            r_starve <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_any) begin
                        r_state <= c_BUSY;
                        r_grant <= w_grant;
                        r_addr  <= w_addr;
                        if (w_grant == c_G_WRITE) begin
                            r_wdata <= write_data;
                        end
                        // Fetch only ages while it is actually waiting.
                        if (w_grant == c_G_FETCH) begin
                            r_starve <= '0;
                        end else if (fetch_enable && (r_starve != c_LIMIT)) begin
                            r_starve <= r_starve + 1'b1;
                        end
                    end
                end
                c_BUSY: begin
                    if (mem_ack) begin
                        if (r_grant != c_G_WRITE) begin
                            r_rdata <= mem_read_data;
                        end
                        r_state <= c_RESPOND;
                    end
                end
                c_RESPOND: r_state <= c_IDLE;
                default:   r_state <= c_IDLE;
            endcase
        end
    end

    assign mem_request    = (r_state == c_BUSY);
    assign mem_write      = (r_state == c_BUSY) && (r_grant == c_G_WRITE);
    assign mem_address    = r_addr;
    assign mem_write_data = r_wdata;
    assign response_data  = r_rdata;
    assign fetch_valid    = (r_state == c_RESPOND) && (r_grant == c_G_FETCH);
    assign read_valid     = (r_state == c_RESPOND) && (r_grant == c_G_READ);
    assign write_done     = (r_state == c_RESPOND) && (r_grant == c_G_WRITE);

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_arbiter
// Description : Self-checking bench for memory_arbiter against a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_arbiter;

    localparam int c_LIMIT = 4;

    logic        clock;
    logic        reset;
    logic        fetch_enable, read_enable, write_enable;
    logic [31:0] fetch_address, read_address, write_address, write_data;
    logic        fetch_valid, read_valid, write_done;
    logic [31:0] response_data;
    logic        mem_request, mem_write;
    logic [31:0] mem_address, mem_write_data;
    logic        mem_ack;
    logic [31:0] mem_read_data;

    int          n_cmp;
    int          n_err;

    // Reference model: outstanding requests per requester (0 fetch, 1 read, 2 write)
    bit          pend [3];
    logic [31:0] addr [3];
    logic [31:0] wdat;
    int          m_starve;
    logic [31:0] m_resp;

    memory_arbiter #(.WIDTH(32), .STARVE_LIMIT(c_LIMIT)) dut (
        .clock          (clock),
        .reset          (reset),
        .fetch_enable   (fetch_enable),
        .fetch_address  (fetch_address),
        .read_enable    (read_enable),
        .read_address   (read_address),
        .write_enable   (write_enable),
        .write_address  (write_address),
        .write_data     (write_data),
        .fetch_valid    (fetch_valid),
        .read_valid     (read_valid),
        .write_done     (write_done),
        .response_data  (response_data),
        .mem_request    (mem_request),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_ack        (mem_ack),
        .mem_read_data  (mem_read_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_req();
        fetch_enable  = pend[0];
        fetch_address = addr[0];
        read_enable   = pend[1];
        read_address  = addr[1];
        write_enable  = pend[2];
        write_address = addr[2];
        write_data    = wdat;
    endtask

    task automatic scramble();
        fetch_enable  = 1'($urandom_range(0, 1));
        read_enable   = 1'($urandom_range(0, 1));
        write_enable  = 1'($urandom_range(0, 1));
        fetch_address = $urandom;
        read_address  = $urandom;
        write_address = $urandom;
        write_data    = $urandom;
    endtask

    task automatic check_pulses(input string tag, input logic [2:0] exp);
        check(tag, {29'b0, fetch_valid, read_valid, write_done}, {29'b0, exp});
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_req"}, {31'b0, mem_request}, 32'h0);
        check({tag, "_wr"}, {31'b0, mem_write}, 32'h0);
        check_pulses({tag, "_pulse"}, 3'b000);
        check({tag, "_resp"}, response_data, m_resp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pend[0] = 0; pend[1] = 0; pend[2] = 0;
        drive_req();
        mem_ack = 1'b0;
        step();
        m_starve = 0;
        m_resp   = 32'h0;
        check_quiet("rst");
        check("rst_addr", mem_address, 32'h0);
        check("rst_wdata", mem_write_data, 32'h0);
        reset = 1'b0;
    endtask

    // One arbitration round starting in IDLE: grant, wait, ack, pulse, back to IDLE.
    task automatic run_txn(input int delay, input logic [31:0] rdata, input bit scram);
        int          w;
        logic [31:0] a;
        logic [2:0]  exp_pulse;
        drive_req();
        mem_ack = 1'($urandom_range(0, 1));
        if (!(pend[0] || pend[1] || pend[2])) begin
            step();
            check_quiet("idle");
        end else begin
            if (m_starve == c_LIMIT && pend[0]) w = 0;
            else if (pend[2]) w = 2;
            else if (pend[1]) w = 1;
            else w = 0;
            a = addr[w];
            if (w == 0) m_starve = 0;
            else if (pend[0] && m_starve < c_LIMIT) m_starve++;
            step();
            check("busy_req", {31'b0, mem_request}, 32'h1);
            check("busy_wr", {31'b0, mem_write}, (w == 2) ? 32'h1 : 32'h0);
            check("busy_addr", mem_address, a);
            if (w == 2) check("busy_wdata", mem_write_data, wdat);
            check_pulses("busy_pulse", 3'b000);
            mem_ack = 1'b0;
            for (int d = 0; d < delay; d++) begin
                if (scram) scramble();
                step();
                check("wait_req", {31'b0, mem_request}, 32'h1);
                check("wait_addr", mem_address, a);
                check_pulses("wait_pulse", 3'b000);
            end
            mem_ack       = 1'b1;
            mem_read_data = rdata;
            if (scram) scramble();
            step();
            if (w != 2) m_resp = rdata;
            exp_pulse = (w == 0) ? 3'b100 : (w == 1) ? 3'b010 : 3'b001;
            check_pulses("resp_pulse", exp_pulse);
            check("resp_req", {31'b0, mem_request}, 32'h0);
            check("resp_data", response_data, m_resp);
            pend[w] = 0;
            drive_req();
            mem_ack       = 1'($urandom_range(0, 1));
            mem_read_data = $urandom;
            step();
            check_quiet("post");
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        addr[0] = 0; addr[1] = 0; addr[2] = 0;
        wdat = 0;
        mem_read_data = 0;
        do_reset();

        // Single read with minimum latency
        pend[1] = 1; addr[1] = 32'h100;
        run_txn(0, 32'hDEADBEEF, 0);
        check("read_result", response_data, 32'hDEADBEEF);

        // Write leaves response_data untouched
        pend[2] = 1; addr[2] = 32'h20; wdat = 32'h5;
        run_txn(0, 32'h12345678, 0);
        check("write_keeps_resp", response_data, 32'hDEADBEEF);

        // All three at once: write, read, fetch
        pend[0] = 1; addr[0] = 32'h40;
        pend[1] = 1; addr[1] = 32'h80;
        pend[2] = 1; addr[2] = 32'hC0; wdat = 32'hA5A5;
        for (int k = 0; k < 3; k++) run_txn(1, 32'h1000 + k, 0);

        // Fetch starvation: reads keep winning until the limit is reached
        do_reset();
        pend[0] = 1; addr[0] = 32'h400;
        for (int k = 0; k < c_LIMIT + 1; k++) begin
            pend[1] = 1; addr[1] = 32'h200 + k;
            run_txn(0, 32'h2000 + k, 0);
        end
        check("starve_fetch_served", {31'b0, pend[0]}, 32'h0);
        pend[1] = 0;

        // Slow memory with inputs wandering during BUSY
        pend[1] = 1; addr[1] = 32'h300;
        run_txn(10, 32'hCAFEF00D, 1);

        // Reset during BUSY abandons the transaction
        pend[2] = 1; addr[2] = 32'h500; wdat = 32'h77;
        drive_req();
        mem_ack = 1'b0;
        step();
        check("mid_busy", {31'b0, mem_request}, 32'h1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        pend[2] = 0;
        drive_req();
        m_starve = 0;
        m_resp   = 32'h0;
        for (int k = 0; k < 3; k++) begin
            mem_ack = 1'b1;
            step();
            check_quiet("after_rst");
            check("after_rst_addr", mem_address, 32'h0);
            check("after_rst_wdata", mem_write_data, 32'h0);
        end
        mem_ack = 1'b0;

        // Randomized traffic with requesters holding until served
        for (int i = 0; i < 120; i++) begin
            for (int r = 0; r < 3; r++) begin
                if (!pend[r] && ($urandom_range(0, 2) != 0)) begin
                    pend[r] = 1;
                    addr[r] = $urandom;
                    if (r == 2) wdat = $urandom;
                end
            end
            run_txn(int'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, which sets the address and data width in bits.
REQ-002 The block SHALL have parameter STARVE_LIMIT, default 4, which sets the number of consecutive lost arbitrations after which fetch gets top priority.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have ports fetch_enable / fetch_address, inputs, 1 / WIDTH bits: instruction read request from the fetch stage.
REQ-006 The block SHALL have ports read_enable / read_address, inputs, 1 / WIDTH bits: data read request from the read stage.
REQ-007 The block SHALL have ports write_enable / write_address / write_data, inputs, 1 / WIDTH / WIDTH bits: store request from the write stage.
REQ-008 The block SHALL have ports fetch_valid / read_valid / write_done, outputs, 1 bit each: one-cycle completion pulses per requester.
REQ-009 The block SHALL have port response_data, output, WIDTH bits: read data, qualified by fetch_valid or read_valid.
REQ-010 The block SHALL have ports mem_request / mem_write, outputs, 1 bit each: memory transaction strobe and direction.
REQ-011 The block SHALL have ports mem_address / mem_write_data, outputs, WIDTH bits each: transaction address and store data.
REQ-012 The block SHALL have ports mem_ack / mem_read_data, inputs, 1 / WIDTH bits: memory completion; read data is valid with mem_ack.

Function
REQ-013 The block SHALL implement the three-state FSM IDLE -> BUSY -> RESPOND -> IDLE.
REQ-014 In IDLE with at least one enable high, the block SHALL select a winner, latch its address (and write_data for a write), and go to BUSY; with no enable high it SHALL stay in IDLE.
REQ-015 Normal priority SHALL be write, then read, then fetch.
REQ-016 When the starvation counter equals STARVE_LIMIT and fetch_enable is high, fetch SHALL win over write and read.
REQ-017 Starvation counter behaviour:
- It SHALL saturate at STARVE_LIMIT.
- It SHALL increment when another requester wins while fetch_enable is high.
- It SHALL clear when fetch wins.
- It SHALL hold otherwise.
REQ-018 In BUSY the block SHALL drive the following from latched values only:
- mem_request=1;
- mem_write=1 for a write grant, else 0;
- mem_address from the latched address;
- mem_write_data from the latched write data.
REQ-019 In BUSY without mem_ack the block SHALL stay in BUSY with all mem_* outputs stable; there is no timeout.
REQ-020 On mem_ack in BUSY the block SHALL register mem_read_data into response_data (read grants only) and go to RESPOND.
REQ-021 In RESPOND the block SHALL assert exactly one of fetch_valid, read_valid or write_done for one cycle, matching the grant, with mem_request=0, then return to IDLE.
REQ-022 Requesters SHALL hold enable and address until their completion pulse.
- A request withdrawn while in BUSY SHALL still complete on memory.
- Its pulse SHALL still be issued.
REQ-023 An enable still high in the IDLE cycle after RESPOND SHALL be treated as a new request.
REQ-024 Latency: request high in IDLE at cycle N with mem_ack at cycle N+1 SHALL give the completion pulse at cycle N+2, which is the minimum.
REQ-025 mem_ack in IDLE or RESPOND SHALL be ignored.
REQ-026 response_data SHALL hold its value between reads, and a write grant SHALL NOT change it.
REQ-027 Arbitration SHALL be evaluated only in IDLE; requests that arrive during BUSY or RESPOND wait.

Reset
REQ-028 While reset is high at a clock edge, the block SHALL set state IDLE, starvation counter 0, response_data 0, and all of mem_request, mem_write, fetch_valid, read_valid and write_done to 0.
REQ-029 Reset in BUSY or RESPOND SHALL abandon the transaction with no completion pulse; a mem_ack arriving after reset SHALL be ignored.
REQ-030 mem_address and mem_write_data SHALL be 0 after reset until the next grant.

Verification
REQ-031 The bench SHALL cover a single read: read_enable=1, read_address=0x100, mem_ack one cycle after mem_request with data 0xDEADBEEF -> mem_write=0, mem_address=0x100, then read_valid pulse with response_data=0xDEADBEEF two cycles after the request.
REQ-032 The bench SHALL cover simultaneous requests: all three enables high in the same IDLE cycle -> grant order write, read, fetch, three BUSY phases, one pulse each.
REQ-033 The bench SHALL cover fetch starvation: fetch_enable held with read_enable continuously re-asserted -> after 4 read grants the 5th grant goes to fetch and the counter returns to 0.
REQ-034 The bench SHALL cover slow memory: mem_ack delayed 10 cycles -> mem_request held 10 cycles with mem_address stable, and no pulse before the ack.
REQ-035 The bench SHALL cover reset mid-transaction: reset in BUSY, then mem_ack -> no pulse, FSM in IDLE, all outputs 0.
REQ-036 The bench SHALL cover a write: write_address=0x20, write_data=0x5 -> mem_write=1, mem_write_data=0x5, write_done pulse, and response_data unchanged.
